ir_command_receiver: RTL and testbench



---
 rtl/ir_protocol_pkg.sv | 34 +++
 rtl/ir_command_receiver_if.sv | 30 +++
 rtl/ir_edge_sync.sv | 38 +++
 rtl/ir_command_receiver.sv | 163 ++++++++++++++++
 tb/tb_ir_command_receiver.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ir_protocol_pkg.sv
// rtl/ir_protocol_pkg.sv - shared SIRC-style IR move-command protocol definitions
package ir_protocol_pkg;

    localparam int CMD_W     = 12;
    localparam int CNT_W     = 17;
    localparam int RPT_W     = 22;
    localparam int BIT_IDX_W = 4;

    // Pulse-width timing at 27 MHz, shared with the transmitter side.
    localparam logic [CNT_W-1:0] START_MIN_CLKS     = 17'd54000;
    localparam logic [CNT_W-1:0] START_MAX_CLKS     = 17'd81000;
    localparam logic [CNT_W-1:0] ONE_MIN_CLKS       = 17'd24300;
    localparam logic [CNT_W-1:0] MARK_MIN_CLKS      = 17'd8100;
    localparam logic [CNT_W-1:0] MARK_MAX_CLKS      = 17'd43200;
    localparam logic [CNT_W-1:0] SPACE_MAX_CLKS     = 17'd32400;
    localparam logic [RPT_W-1:0] REPEAT_WINDOW_CLKS = 22'd2700000;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SPACE = 3'd2,
        ST_BIT   = 3'd3,
        ST_DONE  = 3'd4
    } ir_state_e;

    // Field layout of the move command: distance in [7:0], angle in [11:8].
    typedef struct packed {
        logic [3:0] angle;
        logic [7:0] distance;
    } move_cmd_t;

endpackage

// File: rtl/ir_command_receiver_if.sv
// rtl/ir_command_receiver_if.sv - IR input and decoded command outputs of the receiver
interface ir_command_receiver_if;
    import ir_protocol_pkg::*;

    logic             ir_in;
    logic [CMD_W-1:0] move_command;
    logic             command_valid;
    logic             new_command;
    logic             frame_error;
    logic             busy;

    modport master (
        input  ir_in,
        output move_command,
        output command_valid,
        output new_command,
        output frame_error,
        output busy
    );

    modport slave (
        output ir_in,
        input  move_command,
        input  command_valid,
        input  new_command,
        input  frame_error,
        input  busy
    );

endinterface

// File: rtl/ir_edge_sync.sv
// rtl/ir_edge_sync.sv - 2-flop synchronizer for the active-low IR input with mark edge pulses
module ir_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic ir_in,
    output logic mark,
    output logic mark_rise,
    output logic mark_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic mark_prev_q, mark_prev_d;

    always_comb begin
        sync1_d     = ir_in;
        sync2_d     = sync1_q;
        mark_prev_d = ~sync2_q;
    end

    // Synchronizer resets to the idle (no carrier) level so reset never fakes an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            mark_prev_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            mark_prev_q <= mark_prev_d;
        end
    end

    assign mark      = ~sync2_q;
    assign mark_rise = mark & ~mark_prev_q;
    assign mark_fall = ~mark & mark_prev_q;

endmodule

// File: rtl/ir_command_receiver.sv
// rtl/ir_command_receiver.sv - pulse-width IR frame decoder with repeat-frame suppression
module ir_command_receiver
    import ir_protocol_pkg::*;
#(
    parameter logic [CNT_W-1:0] START_MIN     = START_MIN_CLKS,
    parameter logic [CNT_W-1:0] START_MAX     = START_MAX_CLKS,
    parameter logic [CNT_W-1:0] ONE_MIN       = ONE_MIN_CLKS,
    parameter logic [CNT_W-1:0] MARK_MIN      = MARK_MIN_CLKS,
    parameter logic [CNT_W-1:0] MARK_MAX      = MARK_MAX_CLKS,
    parameter logic [CNT_W-1:0] SPACE_MAX     = SPACE_MAX_CLKS,
    parameter logic [RPT_W-1:0] REPEAT_WINDOW = REPEAT_WINDOW_CLKS
) (
    input  logic                  clock,
    input  logic                  reset,
    ir_command_receiver_if.master bus
);

    logic mark, mark_rise, mark_fall;

    ir_edge_sync u_edge_sync (
        .clock     (clock),
        .reset     (reset),
        .ir_in     (bus.ir_in),
        .mark      (mark),
        .mark_rise (mark_rise),
        .mark_fall (mark_fall)
    );

    ir_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CMD_W-1:0]     shreg_q, shreg_d;
    move_cmd_t            last_cmd_q, last_cmd_d;
    logic [RPT_W-1:0]     rpt_q, rpt_d;
    move_cmd_t            move_command_q, move_command_d;
    logic                 command_valid_q, command_valid_d;
    logic                 new_command_q, new_command_d;
    logic                 frame_error_q, frame_error_d;
    logic                 busy_q, busy_d;

    // cnt_len is the length of the current mark/space including this cycle's sample,
    // so a pulse held for exactly N clocks is measured as N at its terminating edge.
    logic [CNT_W-1:0] cnt_len;
    logic [RPT_W-1:0] rpt_inc;

    assign cnt_len = (&cnt_q) ? cnt_q : cnt_q + 17'd1;
    assign rpt_inc = (&rpt_q) ? rpt_q : rpt_q + 22'd1;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shreg_d         = shreg_q;
        last_cmd_d      = last_cmd_q;
        rpt_d           = rpt_inc;
        move_command_d  = move_command_q;
        command_valid_d = 1'b0;
        new_command_d   = 1'b0;
        frame_error_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mark_rise) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mark_fall) begin
                    cnt_d = '0;
                    if (cnt_len >= START_MIN && cnt_len <= START_MAX) begin
                        bit_idx_d = '0;
                        state_d   = ST_SPACE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end else if (mark) begin
                    cnt_d = cnt_len;
                end
            end
            ST_SPACE: begin
                if (mark_rise) begin
                    cnt_d   = '0;
                    state_d = ST_BIT;
                end else if (cnt_len > SPACE_MAX) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (!mark) begin
                    cnt_d = cnt_len;
                end
            end
            ST_BIT: begin
                // Edge wins over a threshold crossing in the same cycle.
                if (mark_fall) begin
                    cnt_d = '0;
                    if (cnt_len < MARK_MIN) begin
                        frame_error_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        shreg_d   = {(cnt_len >= ONE_MIN), shreg_q[CMD_W-1:1]};
                        bit_idx_d = bit_idx_q + 4'd1;
                        state_d   = (bit_idx_q == LAST_BIT_IDX) ? ST_DONE : ST_SPACE;
                    end
                end else if (cnt_len > MARK_MAX) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (mark) begin
                    cnt_d = cnt_len;
                end
            end
            ST_DONE: begin
                move_command_d  = move_cmd_t'(shreg_q);
                command_valid_d = 1'b1;
                new_command_d   = (shreg_q != CMD_W'(last_cmd_q)) || (rpt_q >= REPEAT_WINDOW);
                last_cmd_d      = move_cmd_t'(shreg_q);
                rpt_d           = '0;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Repeat timer resets saturated so the first frame after reset is always new.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shreg_q         <= '0;
            last_cmd_q      <= '0;
            rpt_q           <= '1;
            move_command_q  <= '0;
            command_valid_q <= 1'b0;
            new_command_q   <= 1'b0;
            frame_error_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shreg_q         <= shreg_d;
            last_cmd_q      <= last_cmd_d;
            rpt_q           <= rpt_d;
            move_command_q  <= move_command_d;
            command_valid_q <= command_valid_d;
            new_command_q   <= new_command_d;
            frame_error_q   <= frame_error_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.move_command  = move_command_q;
    assign bus.command_valid = command_valid_q;
    assign bus.new_command   = new_command_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_ir_command_receiver.sv
// tb/tb_ir_command_receiver.sv - directed self-checking bench for ir_command_receiver (100 clocks per ms)
module tb_ir_command_receiver;

    localparam int START_LEN = 240;
    localparam int SPACE_LEN = 60;
    localparam int ZERO_LEN  = 60;
    localparam int ONE_LEN   = 120;
    localparam int PITCH     = 4500;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ir_command_receiver_if ir_bus ();

    ir_command_receiver #(
        .START_MIN     (17'd200),
        .START_MAX     (17'd300),
        .ONE_MIN       (17'd90),
        .MARK_MIN      (17'd30),
        .MARK_MAX      (17'd160),
        .SPACE_MAX     (17'd120),
        .REPEAT_WINDOW (22'd10000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ir_bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cv_cnt   = 0;
    int nc_cnt   = 0;
    int fe_cnt   = 0;
    int cv0, nc0, fe0;
    int lat;
    int used;

    always @(negedge clock) begin
        if (ir_bus.command_valid) cv_cnt++;
        if (ir_bus.new_command)   nc_cnt++;
        if (ir_bus.frame_error)   fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        cv0 = cv_cnt;
        nc0 = nc_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic hold(input logic level, input int n);
        ir_bus.ir_in = level;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [11:0] cmd, input int nbits, input int start_len,
                             input int one_len, input int zero_len, output int len);
        len = start_len;
        hold(1'b0, start_len);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b1, SPACE_LEN);
            hold(1'b0, cmd[i] ? one_len : zero_len);
            len += SPACE_LEN + (cmd[i] ? one_len : zero_len);
        end
    endtask

    task automatic send_frame(input logic [11:0] cmd, input int start_len, input int one_len,
                              input int zero_len, input int pitch);
        int len;
        send_bits(cmd, 12, start_len, one_len, zero_len, len);
        ir_bus.ir_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (ir_bus.command_valid && lat == 0) lat = k;
        end
        @(negedge clock);
        len += 8;
        if (pitch > len) hold(1'b1, pitch - len);
    endtask

    initial begin
        ir_bus.ir_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_move", ir_bus.move_command, 12'h000);
        check("rst_valid", ir_bus.command_valid, 1'b0);
        check("rst_busy", ir_bus.busy, 1'b0);
        reset = 1'b0;
        hold(1'b1, 20);
        check("idle_busy", ir_bus.busy, 1'b0);

        // clean frame
        snap();
        send_frame(12'h00A, START_LEN, ONE_LEN, ZERO_LEN, 2500);
        check("clean_latency", lat, 4);
        check("clean_move", ir_bus.move_command, 12'h00A);
        check("clean_valid_cnt", cv_cnt - cv0, 1);
        check("clean_new_cnt", nc_cnt - nc0, 1);
        check("clean_err_cnt", fe_cnt - fe0, 0);

        // burst of identical frames, then the same frame after a long idle
        snap();
        repeat (5) send_frame(12'h3C8, START_LEN, ONE_LEN, ZERO_LEN, PITCH);
        check("burst_valid_cnt", cv_cnt - cv0, 5);
        check("burst_new_cnt", nc_cnt - nc0, 1);
        check("burst_err_cnt", fe_cnt - fe0, 0);
        check("burst_move", ir_bus.move_command, 12'h3C8);
        snap();
        hold(1'b1, 15000);
        send_frame(12'h3C8, START_LEN, ONE_LEN, ZERO_LEN, 500);
        check("rearm_valid_cnt", cv_cnt - cv0, 1);
        check("rearm_new_cnt", nc_cnt - nc0, 1);

        // back-to-back distinct commands
        snap();
        send_frame(12'h00A, START_LEN, ONE_LEN, ZERO_LEN, PITCH);
        send_frame(12'h00B, START_LEN, ONE_LEN, ZERO_LEN, PITCH);
        check("b2b_valid_cnt", cv_cnt - cv0, 2);
        check("b2b_new_cnt", nc_cnt - nc0, 2);
        check("b2b_move", ir_bus.move_command, 12'h00B);

        // short start mark
        snap();
        hold(1'b0, 150);
        hold(1'b1, 300);
        check("short_start_err", fe_cnt - fe0, 1);
        check("short_start_valid", cv_cnt - cv0, 0);
        check("short_start_move", ir_bus.move_command, 12'h00B);

        // start mark one clock too long
        snap();
        hold(1'b0, 301);
        hold(1'b1, 300);
        check("long_start_err", fe_cnt - fe0, 1);

        // glitch data mark
        snap();
        hold(1'b0, START_LEN);
        hold(1'b1, SPACE_LEN);
        hold(1'b0, 10);
        hold(1'b1, 300);
        check("glitch_err", fe_cnt - fe0, 1);

        // overlong space after bit 5
        snap();
        send_bits(12'h0FF, 6, START_LEN, ONE_LEN, ZERO_LEN, used);
        hold(1'b1, 200);
        hold(1'b1, 300);
        check("space_err", fe_cnt - fe0, 1);
        check("space_valid", cv_cnt - cv0, 0);
        check("space_move", ir_bus.move_command, 12'h00B);
        check("space_busy", ir_bus.busy, 1'b0);

        // boundary widths
        snap();
        send_frame(12'h001, START_LEN, 90, 89, 2500);
        check("one_min_move", ir_bus.move_command, 12'h001);
        send_frame(12'h5A5, 200, ONE_LEN, ZERO_LEN, 2500);
        check("start_min_move", ir_bus.move_command, 12'h5A5);
        send_frame(12'h5A6, 300, ONE_LEN, ZERO_LEN, 2500);
        check("start_max_move", ir_bus.move_command, 12'h5A6);
        check("bound_valid_cnt", cv_cnt - cv0, 3);
        check("bound_err_cnt", fe_cnt - fe0, 0);

        // async reset in the middle of bit 7
        send_bits(12'h123, 7, START_LEN, ONE_LEN, ZERO_LEN, used);
        hold(1'b1, SPACE_LEN);
        hold(1'b0, 30);
        check("mid_frame_busy", ir_bus.busy, 1'b1);
        reset = 1'b1;
        ir_bus.ir_in = 1'b1;
        #1;
        check("areset_move", ir_bus.move_command, 12'h000);
        check("areset_busy", ir_bus.busy, 1'b0);
        check("areset_valid", ir_bus.command_valid, 1'b0);
        check("areset_new", ir_bus.new_command, 1'b0);
        check("areset_err", ir_bus.frame_error, 1'b0);
        @(negedge clock);
        hold(1'b1, 5);
        reset = 1'b0;
        hold(1'b1, 50);
        snap();
        send_frame(12'hFFF, START_LEN, ONE_LEN, ZERO_LEN, 2500);
        check("post_rst_move", ir_bus.move_command, 12'hFFF);
        check("post_rst_valid_cnt", cv_cnt - cv0, 1);
        check("post_rst_new_cnt", nc_cnt - nc0, 1);
        check("post_rst_err_cnt", fe_cnt - fe0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
